muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide execution unit for the MIPS core, with its own HI/LO register pair.
- Decodes the R-type funct field for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. All other functs go to the ALU path.
- Sits in the execute stage beside the ALU. Gives the control unit a busy/stall indication so HI/LO reads wait for a result in flight.

---
 rtl/muldiv_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/DIV execution unit with private HI/LO registers.
// Optional macro MULDIV_EARLY_OUT_EN: multiply finishes once no multiplier bits remain.
module muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [5:0]        i_func,
    input  logic [DATA_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rt,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_stall,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic [DATA_W-1:0] o_result
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    // multiplicand, shifted left one place per step
    logic [2*DATA_W-1:0] opa_q;
    // multiplier (shifted right per step) or divisor
    logic [DATA_W-1:0]   opb_q;
    // product magnitude, or {remainder, quotient} during divide
    logic [2*DATA_W-1:0] acc_q;
    logic                div_q;
    logic                neg_lo_q;
    logic                neg_hi_q;
    logic                div0_q;
    logic                done_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic dec_mul;
    logic dec_div;
    logic dec_sgn;
    logic dec_mthi;
    logic dec_mtlo;
    logic dec_mf;
    logic dec_any;

    // Funct decode; anything not listed belongs to the ALU.
    always_comb begin
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        dec_sgn  = 1'b0;
        dec_mthi = 1'b0;
        dec_mtlo = 1'b0;
        dec_mf   = 1'b0;
        case (i_func)
            F_MULT: begin
                dec_mul = 1'b1;
                dec_sgn = 1'b1;
            end
            F_MULTU: dec_mul = 1'b1;
            F_DIV: begin
                dec_div = 1'b1;
                dec_sgn = 1'b1;
            end
            F_DIVU: dec_div = 1'b1;
            F_MTHI: dec_mthi = 1'b1;
            F_MTLO: dec_mtlo = 1'b1;
            F_MFHI: dec_mf = 1'b1;
            F_MFLO: dec_mf = 1'b1;
            default: ;
        endcase
    end

    assign dec_any = dec_mul | dec_div | dec_mthi | dec_mtlo | dec_mf;

    logic              rs_neg;
    logic              rt_neg;
    logic [DATA_W-1:0] rs_mag;
    logic [DATA_W-1:0] rt_mag;

    assign rs_neg = dec_sgn & i_rs[DATA_W-1];
    assign rt_neg = dec_sgn & i_rt[DATA_W-1];
    assign rs_mag = rs_neg ? -i_rs : i_rs;
    assign rt_mag = rt_neg ? -i_rt : i_rt;

    logic [2*DATA_W-1:0] mul_acc_d;
    logic                mul_last;

    assign mul_acc_d = opb_q[0] ? acc_q + opa_q : acc_q;

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_last = (cnt_q == LAST) || (opb_q[DATA_W-1:1] == '0);
`else
    assign mul_last = (cnt_q == LAST);
`endif

    logic [DATA_W:0]   div_sh;
    logic [DATA_W:0]   div_diff;
    logic              div_ge;
    logic [DATA_W-1:0] div_rem_d;

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    assign div_sh    = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_diff  = div_sh - {1'b0, opb_q};
    assign div_ge    = (div_sh >= {1'b0, opb_q});
    assign div_rem_d = div_ge ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0];

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    // Sign correction applied in FIX. Divide by zero forces an all-ones
    // quotient; the remainder path then naturally reproduces the dividend.
    assign prod_fix = neg_lo_q ? -acc_q : acc_q;
    assign quo_fix  = div0_q ? '1
                    : (neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0]);
    assign rem_fix  = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W]
                    : acc_q[2*DATA_W-1:DATA_W];

    // Control FSM with datapath registers and HI/LO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        if (dec_mul) begin
                            div_q    <= 1'b0;
                            div0_q   <= 1'b0;
                            neg_lo_q <= rs_neg ^ rt_neg;
                            neg_hi_q <= rs_neg ^ rt_neg;
`ifdef MULDIV_EARLY_OUT_EN
                            // first multiplier bit is consumed while latching
                            acc_q   <= {{DATA_W{1'b0}},
                                        (rt_mag[0] ? rs_mag : {DATA_W{1'b0}})};
                            opa_q   <= {{(DATA_W-1){1'b0}}, rs_mag, 1'b0};
                            opb_q   <= rt_mag >> 1;
                            cnt_q   <= CNT_W'(1);
                            state_q <= (rt_mag[DATA_W-1:1] == '0) ? S_FIX : S_MUL;
`else
                            acc_q   <= '0;
                            opa_q   <= {{DATA_W{1'b0}}, rs_mag};
                            opb_q   <= rt_mag;
                            cnt_q   <= '0;
                            state_q <= S_MUL;
`endif
                        end else if (dec_div) begin
                            div_q    <= 1'b1;
                            div0_q   <= (i_rt == '0);
                            neg_lo_q <= rs_neg ^ rt_neg;
                            neg_hi_q <= rs_neg;
                            acc_q    <= {{DATA_W{1'b0}}, rs_mag};
                            opb_q    <= rt_mag;
                            cnt_q    <= '0;
                            state_q  <= S_DIV;
                        end else if (dec_mthi) begin
                            hi_q <= i_rs;
                        end else if (dec_mtlo) begin
                            lo_q <= i_rs;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_acc_d;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mul_last) begin
                        state_q <= S_FIX;
                    end
                end
                S_DIV: begin
                    acc_q <= {div_rem_d, acc_q[DATA_W-2:0], div_ge};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                        lo_q <= prod_fix[DATA_W-1:0];
                    end
                    done_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_busy   = (state_q != S_IDLE);
    assign o_done   = done_q;
    assign o_stall  = i_start & o_busy & dec_any;
    assign o_hi     = hi_q;
    assign o_lo     = lo_q;
    assign o_result = (i_func == F_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit; expected HI/LO and
// latency are queued at issue and checked by a monitor on o_done.
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam int W = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [5:0]   func;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic         busy;
    logic         done;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] res;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    typedef struct {
        int           id;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           st;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    muldiv_unit #(.DATA_W(W), .CNT_W(6)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_func  (func),
        .i_rs    (rs),
        .i_rt    (rt),
        .o_busy  (busy),
        .o_done  (done),
        .o_stall (stall),
        .o_hi    (hi),
        .o_lo    (lo),
        .o_result(res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // multiply latency: hand value for the early-out build, else fixed 34
    function automatic int ml(int eo_lat);
        return EO ? eo_lat : 34;
    endfunction

    // monitor: pop and compare on every o_done
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: o_done=1 at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("hi[%0d]", mon_e.id), hi, mon_e.hi);
                chk($sformatf("lo[%0d]", mon_e.id), lo, mon_e.lo);
                chk($sformatf("lat[%0d]", mon_e.id), W'(cyc - mon_e.st), W'(mon_e.lat));
            end
        end
    end

    task automatic issue(int id, logic [5:0] f, logic [W-1:0] a, logic [W-1:0] b,
                         bit push, logic [W-1:0] eh, logic [W-1:0] el, int lat);
        exp_t e;
        start = 1'b1;
        func  = f;
        rs    = a;
        rt    = b;
        if (push) begin
            e.id  = id;
            e.hi  = eh;
            e.lo  = el;
            e.st  = cyc;
            e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        func  = '0;
        rs    = '0;
        rt    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        issue(1, F_MULT, 32'hFFFF_FFFD, 32'd7, 1,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, ml(4));
`ifndef MULDIV_EARLY_OUT_EN
        bad = 0;
        for (int k = 1; k <= 33; k++) begin
            if (busy !== 1'b1) bad++;
            @(posedge clk);
            #1;
        end
        chk("busy_window_bad", bad, 0);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        chk("done_cycle34", {31'd0, done}, 32'd1);
`endif
        drain();

        issue(2, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
              32'hFFFF_FFFE, 32'h0000_0001, ml(33));
        drain();
        issue(3, F_MULT, 32'h8000_0000, 32'h8000_0000, 1,
              32'h4000_0000, 32'h0, ml(33));
        drain();
        issue(4, F_DIV, 32'hFFFF_FFF9, 32'd2, 1,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        drain();
        issue(5, F_DIVU, 32'd7, 32'd0, 1,
              32'd7, 32'hFFFF_FFFF, 34);
        drain();
        issue(6, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1,
              32'h0, 32'h8000_0000, 34);
        drain();
        issue(7, F_DIV, 32'd7, 32'hFFFF_FFFE, 1,
              32'd1, 32'hFFFF_FFFD, 34);
        drain();
        issue(8, F_DIV, 32'hFFFF_FFFB, 32'd0, 1,
              32'hFFFF_FFFB, 32'hFFFF_FFFF, 34);
        drain();
        issue(9, F_MULTU, 32'd5, 32'd0, 1, 32'h0, 32'h0, ml(2));
        drain();

        issue(0, F_MTHI, 32'h1234, 32'd0, 0, '0, '0, 0);
        func = F_MFHI;
        #1;
        chk("mfhi_result", res, 32'h1234);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(0, F_MTLO, 32'h5678, 32'd0, 0, '0, '0, 0);
        func = F_MFLO;
        #1;
        chk("mflo_result", res, 32'h5678);
        chk("mtlo_hi_kept", hi, 32'h1234);

        start = 1'b1;
        func  = F_MFHI;
        #1;
        chk("stall_idle", {31'd0, stall}, 32'd0);
        start = 1'b0;
        @(posedge clk);
        #1;

        issue(10, F_MULTU, 32'd5, 32'd3, 1, 32'h0, 32'd15, ml(3));
        start = 1'b1;
        func  = F_MFLO;
        #1;
        chk("stall_mflo", {31'd0, stall}, 32'd1);
        chk("stall_hi_kept", hi, 32'h1234);
        chk("stall_lo_kept", lo, 32'h5678);
        @(posedge clk);
        #1;
        func = F_MULT;
        rs   = 32'd9;
        rt   = 32'd9;
        #1;
        chk("stall_mult", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        issue(0, F_DIV, 32'd100, 32'd7, 0, '0, '0, 0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, '0);
        chk("abort_lo", lo, '0);
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);

        issue(11, F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
              32'h0, 32'h1, ml(2));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
